// File: rtl/random_matrix_bank.sv
// rtl/random_matrix_bank.sv - multi-slot matrix buffer bank filled with LFSR-random, constant or diagonal values
module random_matrix_bank #(
  parameter int                WIDTH   = 8,
  parameter int                MAX_DIM = 5,
  parameter int                SLOTS   = 2,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  localparam int N2 = MAX_DIM * MAX_DIM,
  localparam int DW = $clog2(MAX_DIM + 1),
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int AW = $clog2(N2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [SW-1:0]     slot,
  input  logic [DW-1:0]     row,
  input  logic [DW-1:0]     col,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  output logic              busy,
  output logic              done,
  input  logic [SW-1:0]     rd_slot,
  input  logic [AW-1:0]     rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic [DW-1:0]     rd_rows,
  output logic [DW-1:0]     rd_cols
);

  localparam logic [0:0]        IDLE     = 1'b0;
  localparam logic [0:0]        FILL     = 1'b1;
  localparam int                PW       = 2 * WIDTH + 1;
  localparam logic [LFSR_W-1:0] MASK     = LFSR_W'(16'hB400);
  localparam logic [AW-1:0]     LAST_IDX = AW'(N2 - 1);
  localparam logic [DW-1:0]     DIM_MAX  = DW'(MAX_DIM);
  localparam logic [DW-1:0]     COL_LAST = DW'(MAX_DIM - 1);
  localparam logic [SW:0]       SLOT_LIM = (SW + 1)'(SLOTS);
  localparam logic [AW:0]       ADDR_LIM = (AW + 1)'(N2);

  logic [0:0]        state;
  logic [AW-1:0]     idx;
  logic [DW-1:0]     r_cnt, c_cnt, cur_rows, cur_cols;
  logic [SW-1:0]     cur_slot;
  logic [1:0]        cur_mode;
  logic [WIDTH-1:0]  lo, hi;
  logic [LFSR_W-1:0] lfsr, lfsr_next;
  logic [WIDTH-1:0]  mem [SLOTS][N2];
  logic [DW-1:0]     dim_rows [SLOTS];
  logic [DW-1:0]     dim_cols [SLOTS];
  logic [DW-1:0]     row_clamp, col_clamp;
  logic [WIDTH:0]    span;
  logic [WIDTH-1:0]  rand_val, elem;
  logic              elem_valid, start_slot_ok, cur_slot_ok, rd_ok;

  function automatic logic [DW-1:0] clamp_dim(input logic [DW-1:0] d);
    if (d == '0) return DW'(1);
    if (d > DIM_MAX) return DIM_MAX;
    return d;
  endfunction

  assign busy      = (state == FILL);
  assign row_clamp = clamp_dim(row);
  assign col_clamp = clamp_dim(col);
  assign lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? MASK : '0);

  assign start_slot_ok = {1'b0, slot} < SLOT_LIM;
  assign cur_slot_ok   = {1'b0, cur_slot} < SLOT_LIM;
  assign rd_ok         = ({1'b0, rd_slot} < SLOT_LIM) && ({1'b0, rd_addr} < ADDR_LIM);

  // Scaling the raw LFSR bits by the span keeps every value inside [lo,hi] without a modulo.
  always_comb begin
    span       = {1'b0, hi} - {1'b0, lo} + (WIDTH + 1)'(1);
    rand_val   = lo + WIDTH'((PW'(lfsr[WIDTH-1:0]) * PW'(span)) >> WIDTH);
    elem_valid = (r_cnt < cur_rows) && (c_cnt < cur_cols);
    case (cur_mode)
      2'd1:    elem = lo;
      2'd2:    elem = (r_cnt == c_cnt) ? lo : '0;
      default: elem = rand_val;
    endcase
    if (!elem_valid) elem = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      idx      <= '0;
      r_cnt    <= '0;
      c_cnt    <= '0;
      cur_rows <= '0;
      cur_cols <= '0;
      cur_slot <= '0;
      cur_mode <= '0;
      lo       <= '0;
      hi       <= '0;
      lfsr     <= SEED;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_slot <= slot;
            cur_mode <= mode;
            cur_rows <= row_clamp;
            cur_cols <= col_clamp;
            lo       <= (min_val <= max_val) ? min_val : max_val;
            hi       <= (min_val <= max_val) ? max_val : min_val;
            idx      <= '0;
            r_cnt    <= '0;
            c_cnt    <= '0;
            state    <= FILL;
          end else if (seed_load) begin
            lfsr <= (seed_val == '0) ? SEED : seed_val;
          end
        end
        FILL: begin
          lfsr <= lfsr_next;
          idx  <= idx + AW'(1);
          if (c_cnt == COL_LAST) begin
            c_cnt <= '0;
            r_cnt <= r_cnt + DW'(1);
          end else begin
            c_cnt <= c_cnt + DW'(1);
          end
          if (idx == LAST_IDX) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLOTS; s++) begin
        dim_rows[s] <= '0;
        dim_cols[s] <= '0;
        for (int i = 0; i < N2; i++) mem[s][i] <= '0;
      end
    end else begin
      if (state == IDLE && start && start_slot_ok) begin
        dim_rows[slot] <= row_clamp;
        dim_cols[slot] <= col_clamp;
      end
      if (state == FILL && cur_slot_ok) mem[cur_slot][idx] <= elem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_rows <= '0;
      rd_cols <= '0;
    end else if (rd_ok) begin
      rd_data <= mem[rd_slot][rd_addr];
      rd_rows <= dim_rows[rd_slot];
      rd_cols <= dim_cols[rd_slot];
    end else begin
      rd_data <= '0;
      rd_rows <= '0;
      rd_cols <= '0;
    end
  end

endmodule

// File: tb/tb_random_matrix_bank.sv
// tb/tb_random_matrix_bank.sv - directed self-checking bench for random_matrix_bank
module tb_random_matrix_bank;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [0:0]  slot;
  logic [2:0]  row, col;
  logic [7:0]  min_val, max_val;
  logic        seed_load;
  logic [15:0] seed_val;
  logic        busy, done;
  logic [0:0]  rd_slot;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [2:0]  rd_rows, rd_cols;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  expv [25];
  bit          rng_on = 0;
  int          rng_lo, rng_hi;

  random_matrix_bank dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .slot(slot),
    .row(row), .col(col), .min_val(min_val), .max_val(max_val),
    .seed_load(seed_load), .seed_val(seed_val), .busy(busy), .done(done),
    .rd_slot(rd_slot), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_rows(rd_rows), .rd_cols(rd_cols)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] rmap(input logic [15:0] l, input logic [7:0] lo, input logic [7:0] hi);
    logic [8:0]  span;
    logic [16:0] p;
    span = {1'b0, hi} - {1'b0, lo} + 9'd1;
    p    = {9'd0, l[7:0]} * {8'd0, span};
    return lo + p[15:8];
  endfunction

  // Expected contents of a 5x5 buffer; advances the LFSR model by one step per element.
  task automatic model_fill(input int m, input int rows, input int cols, input int a, input int b);
    logic [15:0] l;
    logic [7:0]  lo, hi, v;
    int          r, c;
    l  = m_lfsr;
    lo = 8'((a < b) ? a : b);
    hi = 8'((a < b) ? b : a);
    for (int k = 0; k < 25; k++) begin
      r = k / 5;
      c = k % 5;
      case (m)
        1:       v = lo;
        2:       v = (r == c) ? lo : 8'd0;
        default: v = rmap(l, lo, hi);
      endcase
      if (!(r < rows && c < cols)) v = 8'd0;
      expv[k] = v;
      l = lstep(l);
    end
    m_lfsr = l;
  endtask

  task automatic load_seed(input logic [15:0] v);
    @(negedge clk);
    seed_load = 1'b1;
    seed_val  = v;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr    = (v == 16'd0) ? 16'hACE1 : v;
  endtask

  task automatic rd(input logic s, input logic [4:0] a, output logic [7:0] d,
                    output logic [2:0] rr, output logic [2:0] cc);
    @(negedge clk);
    rd_slot = s;
    rd_addr = a;
    @(negedge clk);
    d  = rd_data;
    rr = rd_rows;
    cc = rd_cols;
  endtask

  task automatic check_slot(input int s, input int er, input int ec);
    logic [7:0] d;
    logic [2:0] rr, cc;
    for (int a = 0; a < 25; a++) begin
      rd(s[0], 5'(a), d, rr, cc);
      chk($sformatf("slot%0d[%0d]", s, a), int'(d), int'(expv[a]));
      if (rng_on) chk($sformatf("range%0d[%0d]", s, a), int'(d >= 8'(rng_lo) && d <= 8'(rng_hi)), 1);
      if (a == 0) begin
        chk($sformatf("rows%0d", s), int'(rr), er);
        chk($sformatf("cols%0d", s), int'(cc), ec);
      end
    end
  endtask

  // One start pulse, then a fixed 30-sample window counting busy cycles and done pulses.
  task automatic run_fill(input logic [1:0] m, input logic s, input logic [2:0] r, input logic [2:0] c,
                          input logic [7:0] mn, input logic [7:0] mx, input int inj, input logic sl);
    int busy_cnt, done_cnt, done_at;
    @(negedge clk);
    mode = m; slot = s; row = r; col = c; min_val = mn; max_val = mx;
    start = 1'b1; seed_load = sl; seed_val = 16'h1234;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      seed_load = 1'b0;
      start     = (k == inj);
      if (k == inj) begin
        mode = 2'd1; slot = ~s; min_val = 8'hEE; max_val = 8'hEE;
      end
    end
    start = 1'b0;
    chk("busy_cycles", busy_cnt, 25);
    chk("done_pulses", done_cnt, 1);
    chk("done_latency", done_at, 25);
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; slot = 1'b0; row = 3'd0; col = 3'd0;
    min_val = 8'd0; max_val = 8'd0; seed_load = 1'b0; seed_val = 16'd0;
    rd_slot = 1'b0; rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst_n  = 1'b1;
    m_lfsr = 16'hACE1;
    for (int k = 0; k < 25; k++) expv[k] = 8'd0;
    check_slot(0, 0, 0);
    check_slot(1, 0, 0);

    // constant fill 2x3 into slot 0
    model_fill(1, 2, 3, 7, 9);
    run_fill(2'd1, 1'b0, 3'd2, 3'd3, 8'd7, 8'd9, -1, 1'b0);
    check_slot(0, 2, 3);

    // reversed bounds random fill, then identical refill from the same seed via mode 3
    load_seed(16'h1234);
    model_fill(0, 5, 5, 50, 10);
    run_fill(2'd0, 1'b1, 3'd5, 3'd5, 8'd50, 8'd10, -1, 1'b0);
    rng_on = 1; rng_lo = 10; rng_hi = 50;
    check_slot(1, 5, 5);
    load_seed(16'h1234);
    model_fill(3, 5, 5, 50, 10);
    run_fill(2'd3, 1'b0, 3'd5, 3'd5, 8'd50, 8'd10, -1, 1'b0);
    check_slot(0, 5, 5);
    check_slot(1, 5, 5);
    rng_on = 0;

    // dimension clamp 0x7 -> 1x5, zero seed means reset seed
    load_seed(16'h0000);
    model_fill(0, 1, 5, 20, 20);
    run_fill(2'd0, 1'b1, 3'd0, 3'd7, 8'd20, 8'd20, -1, 1'b0);
    check_slot(1, 1, 5);
    load_seed(16'h0000);
    model_fill(0, 2, 2, 0, 255);
    run_fill(2'd0, 1'b0, 3'd2, 3'd2, 8'd0, 8'd255, -1, 1'b1);
    check_slot(0, 2, 2);
    begin
      logic [7:0] d;
      logic [2:0] rr, cc;
      rd(1'b0, 5'd25, d, rr, cc);
      chk("oob_addr25", int'(d), 0);
      rd(1'b1, 5'd31, d, rr, cc);
      chk("oob_addr31", int'(d), 0);
      chk("oob_rows31", int'(rr), 0);
    end

    // diagonal fill with a second start pulse mid-fill
    model_fill(2, 4, 4, 3, 200);
    run_fill(2'd2, 1'b0, 3'd4, 3'd4, 8'd3, 8'd200, 10, 1'b0);
    check_slot(0, 4, 4);
    for (int k = 0; k < 25; k++) expv[k] = (k < 5) ? 8'd20 : 8'd0;
    check_slot(1, 1, 5);

    // reset during a fill
    @(negedge clk);
    mode = 2'd1; slot = 1'b1; row = 3'd5; col = 3'd5; min_val = 8'd9; max_val = 8'd9; start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    m_lfsr = 16'hACE1;
    for (int k = 0; k < 25; k++) expv[k] = 8'd0;
    check_slot(0, 0, 0);
    check_slot(1, 0, 0);
    model_fill(0, 5, 5, 0, 255);
    run_fill(2'd0, 1'b0, 3'd5, 3'd5, 8'd0, 8'd255, -1, 1'b0);
    check_slot(0, 5, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
